// File: rtl/sting_axil_regfile.sv
// rtl/sting_axil_regfile.sv - AXI4-Lite config/status register file for the sting core
// Optional done interrupt and IRQ_EN register: define STING_REG_IRQ_EN.
module sting_axil_regfile #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 32,
  parameter int                NUM_REGS = 16,
  parameter logic [DATA_W-1:0] ID_VALUE = 32'h5354_0001
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [ADDR_W-1:0]          s_awaddr,
  input  logic                       s_awvalid,
  output logic                       s_awready,
  input  logic [DATA_W-1:0]          s_wdata,
  input  logic [DATA_W/8-1:0]        s_wstrb,
  input  logic                       s_wvalid,
  output logic                       s_wready,
  output logic [1:0]                 s_bresp,
  output logic                       s_bvalid,
  input  logic                       s_bready,
  input  logic [ADDR_W-1:0]          s_araddr,
  input  logic                       s_arvalid,
  output logic                       s_arready,
  output logic [DATA_W-1:0]          s_rdata,
  output logic [1:0]                 s_rresp,
  output logic                       s_rvalid,
  input  logic                       s_rready,
  input  logic                       core_busy,
  input  logic                       core_done,
  output logic                       reg_ctrl_reset,
  output logic                       reg_ctrl_run,
  output logic [NUM_REGS*DATA_W-1:0] reg_flat,
  output logic                       irq
);
  localparam int WA = ADDR_W - 2;
  localparam int NB = DATA_W / 8;
  localparam logic [WA:0]   MAP_END  = (WA+1)'(4 + NUM_REGS);
  localparam logic [WA-1:0] A_CTRL   = WA'(0);
  localparam logic [WA-1:0] A_STATUS = WA'(1);
  localparam logic [WA-1:0] A_IRQEN  = WA'(2);
  localparam logic [WA-1:0] A_ID     = WA'(3);

  logic              aw_full_q, aw_full_d, w_full_q, w_full_d;
  logic              bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic              awready_q, wready_q, arready_q;
  logic [WA-1:0]     aw_word_q;
  logic [DATA_W-1:0] w_data_q;
  logic [NB-1:0]     w_strb_q;
  logic [1:0]        bresp_q, rresp_q;
  logic [DATA_W-1:0] rdata_q;
  logic              run_q, ctrl_reset_q, busy_q, done_q, done_d;
  logic [DATA_W-1:0] gen_q [NUM_REGS];
`ifdef STING_REG_IRQ_EN
  logic              irq_en_q, irq_q;
`endif

  logic              aw_hs, w_hs, ar_hs, b_hs, r_hs, commit;
  logic [WA-1:0]     ar_word;
  logic              rd_err, wr_err, wr_ctrl, clr_done;
  logic [DATA_W-1:0] rd_val;
  logic              unused_addr_lsbs;

  assign aw_hs    = s_awvalid & awready_q;
  assign w_hs     = s_wvalid & wready_q;
  assign ar_hs    = s_arvalid & arready_q;
  assign b_hs     = bvalid_q & s_bready;
  assign r_hs     = rvalid_q & s_rready;
  assign commit   = aw_full_q & w_full_q & ~bvalid_q;
  assign ar_word  = s_araddr[ADDR_W-1:2];
  assign wr_err   = ({1'b0, aw_word_q} >= MAP_END);
  assign wr_ctrl  = commit & (aw_word_q == A_CTRL) & w_strb_q[0];
  assign clr_done = commit & (aw_word_q == A_STATUS) & w_strb_q[0] & w_data_q[1];
  // A done pulse in the same cycle as the clearing write keeps DONE set
  assign done_d   = core_done | (done_q & ~clr_done);
  assign unused_addr_lsbs = &{1'b0, s_awaddr[1:0], s_araddr[1:0]};

  always_comb begin
    rd_val = '0;
    rd_err = ({1'b0, ar_word} >= MAP_END);
    case (ar_word)
      A_CTRL:   rd_val[1] = run_q;
      A_STATUS: rd_val[1:0] = {done_q, busy_q};
      A_IRQEN: begin
`ifdef STING_REG_IRQ_EN
        rd_val[0] = irq_en_q;
`endif
      end
      A_ID:     rd_val = ID_VALUE;
      default: begin
        for (int i = 0; i < NUM_REGS; i++)
          if (ar_word == WA'(i + 4)) rd_val = gen_q[i];
      end
    endcase
  end

  always_comb begin
    aw_full_d = aw_full_q;
    w_full_d  = w_full_q;
    bvalid_d  = bvalid_q;
    rvalid_d  = rvalid_q;
    if (aw_hs)  aw_full_d = 1'b1;
    if (w_hs)   w_full_d  = 1'b1;
    if (commit) bvalid_d  = 1'b1;
    if (b_hs) begin
      bvalid_d  = 1'b0;
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
    end
    if (ar_hs)     rvalid_d = 1'b1;
    else if (r_hs) rvalid_d = 1'b0;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      aw_full_q    <= 1'b0;
      w_full_q     <= 1'b0;
      bvalid_q     <= 1'b0;
      rvalid_q     <= 1'b0;
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      arready_q    <= 1'b0;
      aw_word_q    <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      bresp_q      <= 2'b00;
      rresp_q      <= 2'b00;
      rdata_q      <= '0;
      run_q        <= 1'b0;
      ctrl_reset_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) gen_q[i] <= '0;
    end else begin
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      awready_q <= ~aw_full_d;
      wready_q  <= ~w_full_d;
      arready_q <= ~rvalid_d;
      if (aw_hs) aw_word_q <= s_awaddr[ADDR_W-1:2];
      if (w_hs) begin
        w_data_q <= s_wdata;
        w_strb_q <= s_wstrb;
      end
      if (commit) bresp_q <= wr_err ? 2'b10 : 2'b00;
      if (ar_hs) begin
        rdata_q <= rd_val;
        rresp_q <= rd_err ? 2'b10 : 2'b00;
      end
      busy_q       <= core_busy;
      done_q       <= done_d;
      ctrl_reset_q <= wr_ctrl & w_data_q[0];
      if (wr_ctrl) run_q <= w_data_q[1] & ~w_data_q[0];
      for (int i = 0; i < NUM_REGS; i++)
        if (commit && aw_word_q == WA'(i + 4))
          for (int k = 0; k < NB; k++)
            if (w_strb_q[k]) gen_q[i][k*8 +: 8] <= w_data_q[k*8 +: 8];
    end
  end

`ifdef STING_REG_IRQ_EN
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (commit && aw_word_q == A_IRQEN && w_strb_q[0]) irq_en_q <= w_data_q[0];
      irq_q <= done_q & irq_en_q;
    end
  end
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_flat[g*DATA_W +: DATA_W] = gen_q[g];
  end

  assign s_awready      = awready_q;
  assign s_wready       = wready_q;
  assign s_bvalid       = bvalid_q;
  assign s_bresp        = bresp_q;
  assign s_arready      = arready_q;
  assign s_rvalid       = rvalid_q;
  assign s_rdata        = rdata_q;
  assign s_rresp        = rresp_q;
  assign reg_ctrl_run   = run_q;
  assign reg_ctrl_reset = ctrl_reset_q;
endmodule

// File: tb/tb_sting_axil_regfile.sv
// tb/tb_sting_axil_regfile.sv - randomized and directed bench for sting_axil_regfile
module tb_sting_axil_regfile;
  localparam int NR = 16;
`ifdef STING_REG_IRQ_EN
  localparam bit IRQ_BUILD = 1'b1;
`else
  localparam bit IRQ_BUILD = 1'b0;
`endif

  logic              aclk = 1'b0;
  logic              areset = 1'b0;
  logic [7:0]        s_awaddr = '0, s_araddr = '0;
  logic              s_awvalid = 0, s_wvalid = 0, s_bready = 0, s_arvalid = 0, s_rready = 0;
  logic [31:0]       s_wdata = '0;
  logic [3:0]        s_wstrb = '0;
  logic              s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]        s_bresp, s_rresp;
  logic [31:0]       s_rdata;
  logic              core_busy, core_done;
  logic              reg_ctrl_reset, reg_ctrl_run, irq;
  logic [NR*32-1:0]  reg_flat;

  sting_axil_regfile #(.ADDR_W(8), .DATA_W(32), .NUM_REGS(NR), .ID_VALUE(32'h5354_0001)) dut (
    .aclk(aclk), .areset(areset),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .core_busy(core_busy), .core_done(core_done),
    .reg_ctrl_reset(reg_ctrl_reset), .reg_ctrl_run(reg_ctrl_run),
    .reg_flat(reg_flat), .irq(irq)
  );

  always #5 aclk = ~aclk;

  int n_chk = 0;
  int n_pass = 0;
  bit rand_core = 0;
  bit done_req = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic tmo(input string nm);
    n_chk++;
    $display("FAIL %s: got timeout expected handshake (t=%0t)", nm, $time);
  endtask

  // Behavioural model: register contents plus the outstanding-transaction bookkeeping
  logic [31:0] m_gen [NR];
  bit          m_run, m_rst_pulse, m_done, m_busy, m_irqen, m_irq;
  bit          m_awfull, m_wfull, m_bvalid, m_rvalid, m_awready, m_wready, m_arready;
  logic [7:0]  m_awaddr;
  logic [31:0] m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;
  bit          e_aw, e_w, e_ar, e_b, e_r, e_commit, e_clr, e_irq;
  int          e_word;

  function automatic bit mapped(input logic [7:0] a);
    return int'(a) < 16 + 4 * NR;
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    int w;
    w = int'(a) / 4;
    if (w == 0) return {30'b0, m_run, 1'b0};
    if (w == 1) return {30'b0, m_done, m_busy};
    if (w == 2) return IRQ_BUILD ? {31'b0, m_irqen} : 32'h0;
    if (w == 3) return 32'h5354_0001;
    if (w < 4 + NR) return m_gen[w-4];
    return 32'h0;
  endfunction

  always @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < NR; i++) m_gen[i] = '0;
      {m_run, m_rst_pulse, m_done, m_busy, m_irqen, m_irq} = '0;
      {m_awfull, m_wfull, m_bvalid, m_rvalid, m_awready, m_wready, m_arready} = '0;
      m_awaddr = '0; m_wdata = '0; m_wstrb = '0;
      m_rdata = '0; m_bresp = '0; m_rresp = '0;
    end else begin
      e_aw = s_awvalid && m_awready;
      e_w  = s_wvalid && m_wready;
      e_ar = s_arvalid && m_arready;
      e_b  = m_bvalid && s_bready;
      e_r  = m_rvalid && s_rready;
      e_commit = m_awfull && m_wfull && !m_bvalid;
      e_irq = IRQ_BUILD && m_done && m_irqen;
      e_clr = 0;
      m_rst_pulse = 0;
      if (e_ar) begin
        m_rdata = m_read(s_araddr);
        m_rresp = mapped(s_araddr) ? 2'b00 : 2'b10;
        m_rvalid = 1;
      end else if (e_r) m_rvalid = 0;
      if (e_commit) begin
        m_bvalid = 1;
        m_bresp = mapped(m_awaddr) ? 2'b00 : 2'b10;
        e_word = int'(m_awaddr) / 4;
        if (e_word == 0 && m_wstrb[0]) begin
          if (m_wdata[0]) begin m_rst_pulse = 1; m_run = 0; end
          else m_run = m_wdata[1];
        end
        if (e_word == 1 && m_wstrb[0] && m_wdata[1]) e_clr = 1;
        if (e_word == 2 && m_wstrb[0] && IRQ_BUILD) m_irqen = m_wdata[0];
        if (e_word >= 4 && e_word < 4 + NR)
          for (int b = 0; b < 4; b++)
            if (m_wstrb[b]) m_gen[e_word-4][8*b +: 8] = m_wdata[8*b +: 8];
      end
      if (e_b) begin m_bvalid = 0; m_awfull = 0; m_wfull = 0; end
      if (e_aw) begin m_awfull = 1; m_awaddr = s_awaddr; end
      if (e_w) begin m_wfull = 1; m_wdata = s_wdata; m_wstrb = s_wstrb; end
      m_done = core_done ? 1'b1 : (e_clr ? 1'b0 : m_done);
      m_busy = core_busy;
      m_irq  = e_irq;
      m_awready = !m_awfull;
      m_wready  = !m_wfull;
      m_arready = !m_rvalid;
    end
  end

  logic [NR*32-1:0] exp_flat;
  always @(negedge aclk) begin
    for (int i = 0; i < NR; i++) exp_flat[i*32 +: 32] = m_gen[i];
    chk("awready", s_awready, m_awready);
    chk("wready", s_wready, m_wready);
    chk("arready", s_arready, m_arready);
    chk("bvalid", s_bvalid, m_bvalid);
    chk("bresp", s_bresp, m_bresp);
    chk("rvalid", s_rvalid, m_rvalid);
    chk("rdata", s_rdata, m_rdata);
    chk("rresp", s_rresp, m_rresp);
    chk("reg_flat", reg_flat, exp_flat);
    chk("ctrl_run", reg_ctrl_run, m_run);
    chk("ctrl_reset", reg_ctrl_reset, m_rst_pulse);
    chk("irq", irq, m_irq);
  end

  initial begin
    core_busy = 0;
    core_done = 0;
    forever begin
      @(posedge aclk); #2;
      if (rand_core) begin
        core_busy = 1'($urandom_range(0, 1));
        core_done = ($urandom_range(0, 7) == 0);
      end else begin
        core_busy = 0;
        core_done = done_req;
      end
    end
  end

  task automatic step();
    @(posedge aclk); #1;
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] st,
                           input int aw_dly, input int w_dly, input int b_dly, output logic [1:0] resp);
    int t;
    bit aw_done, w_done, aw_fire, w_fire;
    t = 0; aw_done = 0; w_done = 0; resp = 'x;
    while (!(aw_done && w_done) && t < 100) begin
      s_awaddr = a; s_wdata = d; s_wstrb = st;
      s_awvalid = !aw_done && t >= aw_dly;
      s_wvalid = !w_done && t >= w_dly;
      aw_fire = s_awvalid && s_awready;
      w_fire = s_wvalid && s_wready;
      step();
      if (aw_fire) aw_done = 1;
      if (w_fire) w_done = 1;
      t++;
    end
    s_awvalid = 0; s_wvalid = 0;
    if (!(aw_done && w_done)) begin tmo("aw_w_handshake"); return; end
    for (t = 0; t < 100; t++) begin
      s_bready = (t >= b_dly);
      if (s_bvalid && s_bready) begin
        resp = s_bresp;
        step();
        s_bready = 0;
        return;
      end
      step();
    end
    s_bready = 0;
    tmo("b_handshake");
  endtask

  task automatic axi_read(input logic [7:0] a, input int ar_dly, input int r_dly,
                          output logic [31:0] data, output logic [1:0] resp);
    int t;
    bit fired;
    t = 0; fired = 0; data = 'x; resp = 'x;
    while (!fired && t < 100) begin
      s_araddr = a;
      s_arvalid = (t >= ar_dly);
      fired = s_arvalid && s_arready;
      step();
      t++;
    end
    s_arvalid = 0;
    if (!fired) begin tmo("ar_handshake"); return; end
    for (t = 0; t < 100; t++) begin
      s_rready = (t >= r_dly);
      if (s_rvalid && s_rready) begin
        data = s_rdata; resp = s_rresp;
        step();
        s_rready = 0;
        return;
      end
      step();
    end
    s_rready = 0;
    tmo("r_handshake");
  endtask

  function automatic logic [7:0] rand_addr();
    if ($urandom_range(0, 4) == 0) return 8'($urandom_range(8'h50, 8'hFF));
    return 8'($urandom_range(0, 4 + NR - 1) * 4 + $urandom_range(0, 3));
  endfunction

  task automatic rand_op();
    logic [7:0] wa, ra;
    logic [31:0] d, rd;
    logic [3:0] st;
    logic [1:0] r1, r2;
    int kind;
    wa = rand_addr();
    ra = ($urandom_range(0, 3) == 0) ? wa : rand_addr();
    d = $urandom;
    st = 4'($urandom_range(0, 15));
    kind = $urandom_range(0, 2);
    if (kind == 0) axi_write(wa, d, st, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3), r1);
    else if (kind == 1) axi_read(ra, $urandom_range(0, 3), $urandom_range(0, 3), rd, r2);
    else fork
      axi_write(wa, d, st, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3), r1);
      axi_read(ra, $urandom_range(0, 3), $urandom_range(0, 3), rd, r2);
    join
  endtask

  task automatic do_reset();
    areset = 1; #1;
    chk("rst_awready", s_awready, 0);
    chk("rst_bvalid", s_bvalid, 0);
    chk("rst_rdata", s_rdata, 0);
    chk("rst_flat", reg_flat, 0);
    chk("rst_irq", irq, 0);
    step(); step();
    areset = 0;
    step(); step();
    chk("post_rst_awready", s_awready, 1);
  endtask

  logic [1:0]  r;
  logic [31:0] d;
  int          pulses;

  initial begin
    #1 do_reset();

    axi_write(8'h10, 32'h8000_0000, 4'hF, 0, 0, 0, r);
    chk("w10_bresp", r, 2'b00);
    axi_read(8'h10, 0, 0, d, r);
    chk("r10_data", d, 32'h8000_0000);
    chk("r10_rresp", r, 2'b00);

    axi_write(8'h14, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, r);
    axi_write(8'h14, 32'h0000_1234, 4'b0011, 0, 0, 0, r);
    axi_read(8'h14, 0, 0, d, r);
    chk("r14_strobe", d, 32'hFFFF_1234);
    axi_write(8'h14, 32'h5555_5555, 4'b0000, 0, 0, 1, r);
    chk("w14_nostrb_bresp", r, 2'b00);

    axi_write(8'h18, 32'hCAFE_0018, 4'hF, 0, 5, 2, r);
    axi_read(8'h18, 0, 3, d, r);
    chk("r18_late_w", d, 32'hCAFE_0018);

    axi_read(8'h50, 0, 0, d, r);
    chk("r50_rresp", r, 2'b10);
    chk("r50_rdata", d, 32'h0);
    axi_write(8'h50, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, r);
    chk("w50_bresp", r, 2'b10);
    axi_read(8'h0C, 0, 0, d, r);
    chk("id", d, 32'h5354_0001);
    axi_write(8'h0C, 32'h0, 4'hF, 0, 0, 0, r);
    chk("wid_bresp", r, 2'b00);

    axi_write(8'h00, 32'h2, 4'hF, 0, 0, 0, r);
    chk("run_on", reg_ctrl_run, 1);
    pulses = 0;
    fork
      axi_write(8'h00, 32'h3, 4'hF, 0, 0, 0, r);
      for (int i = 0; i < 12; i++) begin @(negedge aclk); if (reg_ctrl_reset) pulses++; end
    join
    chk("reset_pulse_count", pulses, 1);
    chk("run_off", reg_ctrl_run, 0);
    axi_read(8'h00, 0, 0, d, r);
    chk("ctrl_read", d, 32'h0);

    axi_write(8'h1C, 32'hAAAA_5555, 4'hF, 0, 0, 0, r);
    fork
      axi_write(8'h1C, 32'h1234_5678, 4'hF, 0, 0, 0, r);
      begin step(); axi_read(8'h1C, 0, 0, d, r); end
    join
    chk("rw_same_cycle", d, 32'hAAAA_5555);
    axi_read(8'h1C, 0, 0, d, r);
    chk("rw_after", d, 32'h1234_5678);

    axi_write(8'h08, 32'h1, 4'hF, 0, 0, 0, r);
    done_req = 1; step(); done_req = 0; step(); step();
    axi_read(8'h04, 0, 0, d, r);
    chk("status_done", d, 32'h2);
    chk("irq_on", irq, IRQ_BUILD);
    axi_write(8'h04, 32'h2, 4'hF, 0, 0, 0, r);
    step(); step();
    chk("irq_off", irq, 0);
    axi_read(8'h04, 0, 0, d, r);
    chk("status_clr", d, 32'h0);
    fork
      axi_write(8'h04, 32'h2, 4'hF, 0, 0, 0, r);
      begin step(); done_req = 1; step(); done_req = 0; end
    join
    axi_read(8'h04, 0, 0, d, r);
    chk("set_wins", d, 32'h2);

    s_awaddr = 8'h20; s_awvalid = 1; step(); s_awvalid = 0;
    do_reset();
    axi_write(8'h24, 32'h0BAD_F00D, 4'hF, 0, 0, 0, r);
    chk("w24_after_rst", r, 2'b00);
    axi_read(8'h24, 0, 0, d, r);
    chk("r24_after_rst", d, 32'h0BAD_F00D);
    axi_read(8'h20, 0, 0, d, r);
    chk("r20_dropped", d, 32'h0);

    rand_core = 1;
    for (int it = 0; it < 250; it++) rand_op();
    rand_core = 0;
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: got no finish expected finish within 900us");
    $fatal(1);
  end
endmodule
